pc_unit: RTL and testbench

Program-counter stage of the RISC-V core, directly downstream of the PC decoder. Holds the architectural PC and issues fetch requests to instruction memory. Commits the next PC selected by PCSrc (sequential, PC-relative branch/jal target, or jalr target), and redirects to a trap vector on reserved selections or misaligned targets. Also maintains a retired-instruction counter and a fault-PC register for the trap handler.

---
 rtl/pc_unit_if.sv | 29 ++
 rtl/pc_unit.sv | 101 ++++++++++
 tb/tb_pc_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Bundle between the PC decoder / fetch side and the program-counter stage.
// The slave side is pc_unit; the master side drives the next-PC selection.
interface pc_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic [1:0]      PCSrc;
    logic [XLEN-1:0] ImmExt;
    logic [XLEN-1:0] ALUResult;
    logic            InstrValid;
    logic            Stall;
    logic            FetchReq;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PCPlus4;
    logic [XLEN-1:0] PCTarget;
    logic            Trap;
    logic            Misaligned;
    logic [XLEN-1:0] FaultPC;
    logic [31:0]     RetireCount;

    modport master (
        output PCSrc, ImmExt, ALUResult, InstrValid, Stall,
        input  FetchReq, PC, PCPlus4, PCTarget, Trap, Misaligned, FaultPC, RetireCount
    );

    modport slave (
        input  PCSrc, ImmExt, ALUResult, InstrValid, Stall,
        output FetchReq, PC, PCPlus4, PCTarget, Trap, Misaligned, FaultPC, RetireCount
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter stage: holds the architectural PC, commits the selected next PC
// and redirects to TRAP_VEC on reserved selections or misaligned targets.
module pc_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100)
) (
    input  logic        CLK,
    input  logic        nRST,
    pc_unit_if.slave    bus
);
    typedef enum logic [1:0] {BOOT, FETCH, TRAP} state_t;

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic [31:0]     retire_q, retire_d;
    logic            fetch_req_q, fetch_req_d;
    logic            trap_q, trap_d;
    logic            mis_q, mis_d;

    logic [XLEN-1:0] pc_plus4, pc_target, cand;
    logic            commit, reserved, bad_align;

    assign pc_plus4  = pc_q + FOUR;
    assign pc_target = pc_q + bus.ImmExt;
    assign commit    = (state_q == FETCH) & bus.InstrValid & ~bus.Stall;
    assign reserved  = (bus.PCSrc == 2'b11);

    always_comb begin
        case (bus.PCSrc)
            2'b01:   cand = pc_target;
            2'b10:   cand = {bus.ALUResult[XLEN-1:1], 1'b0};
            default: cand = pc_plus4;
        endcase
    end

    // Reserved selection traps regardless of the candidate, and is never reported as misaligned.
    assign bad_align = ~reserved & (cand[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        retire_d   = retire_q;
        trap_d     = 1'b0;
        mis_d      = 1'b0;
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: begin
                if (commit) begin
                    if (reserved | bad_align) begin
                        state_d    = TRAP;
                        pc_d       = TRAP_VEC;
                        fault_pc_d = pc_q;
                        trap_d     = 1'b1;
                        mis_d      = bad_align;
                    end else begin
                        pc_d     = cand;
                        retire_d = retire_q + 32'd1;
                    end
                end
            end
            TRAP:    state_d = FETCH;
            default: state_d = BOOT;
        endcase
        // Registered so FetchReq carries no combinational path from the inputs.
        fetch_req_d = (state_d == FETCH);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VEC;
            fault_pc_q  <= '0;
            retire_q    <= '0;
            fetch_req_q <= 1'b0;
            trap_q      <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fault_pc_q  <= fault_pc_d;
            retire_q    <= retire_d;
            fetch_req_q <= fetch_req_d;
            trap_q      <= trap_d;
            mis_q       <= mis_d;
        end
    end

    assign bus.FetchReq    = fetch_req_q;
    assign bus.PC          = pc_q;
    assign bus.PCPlus4     = pc_plus4;
    assign bus.PCTarget    = pc_target;
    assign bus.Trap        = trap_q;
    assign bus.Misaligned  = mis_q;
    assign bus.FaultPC     = fault_pc_q;
    assign bus.RetireCount = retire_q;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, async-reset sequence, and a
// randomized run against a behavioural next-PC model.
module tb_pc_unit;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    pc_unit_if #(.XLEN(32)) bus ();

    pc_unit #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(TRAP_VEC)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  src;
        logic [31:0] imm, alu;
        logic        valid, stall;
        logic [31:0] p4_pre, tgt_pre;
        logic [31:0] pc;
        logic        fetch, trap, mis;
        logic [31:0] fault, rc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] src, logic [31:0] imm, logic [31:0] alu,
                                logic valid, logic stall, logic [31:0] p4_pre,
                                logic [31:0] tgt_pre, logic [31:0] pc, logic fetch,
                                logic trap, logic mis, logic [31:0] fault, logic [31:0] rc);
        vec_t v;
        v.src = src; v.imm = imm; v.alu = alu; v.valid = valid; v.stall = stall;
        v.p4_pre = p4_pre; v.tgt_pre = tgt_pre; v.pc = pc; v.fetch = fetch;
        v.trap = trap; v.mis = mis; v.fault = fault; v.rc = rc;
        return v;
    endfunction

    task automatic drive(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu,
                         input logic valid, input logic stall);
        bus.PCSrc = src; bus.ImmExt = imm; bus.ALUResult = alu;
        bus.InstrValid = valid; bus.Stall = stall;
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] pc, input logic fetch,
                            input logic trap, input logic mis, input logic [31:0] fault,
                            input logic [31:0] rc);
        chk({tag, ".PC"}, bus.PC, pc);
        chk({tag, ".FetchReq"}, 32'(bus.FetchReq), 32'(fetch));
        chk({tag, ".Trap"}, 32'(bus.Trap), 32'(trap));
        chk({tag, ".Misaligned"}, 32'(bus.Misaligned), 32'(mis));
        chk({tag, ".FaultPC"}, bus.FaultPC, fault);
        chk({tag, ".RetireCount"}, bus.RetireCount, rc);
    endtask

    // Behavioural model state
    logic [31:0] m_pc, m_rc, m_fault;
    bit          m_booting, m_in_trap, m_trap, m_mis;

    task automatic model_reset();
        m_pc = 32'h0; m_rc = 0; m_fault = 0;
        m_booting = 1; m_in_trap = 0; m_trap = 0; m_mis = 0;
    endtask

    task automatic model_step(input logic [1:0] src, input logic [31:0] imm,
                              input logic [31:0] alu, input logic valid, input logic stall);
        logic [31:0] dest;
        m_trap = 0; m_mis = 0;
        if (m_booting) m_booting = 0;
        else if (m_in_trap) m_in_trap = 0;
        else if (valid && !stall) begin
            case (src)
                2'd0:    dest = m_pc + 4;
                2'd1:    dest = m_pc + imm;
                2'd2:    dest = alu & 32'hFFFF_FFFE;
                default: dest = 32'h0;
            endcase
            if (src == 2'd3 || (dest % 4) != 0) begin
                m_fault = m_pc; m_pc = TRAP_VEC; m_in_trap = 1;
                m_trap = 1; m_mis = (src != 2'd3);
            end else begin
                m_pc = dest; m_rc = m_rc + 1;
            end
        end
    endtask

    initial begin
        // src imm alu v s | p4_pre tgt_pre | pc fetch trap mis fault rc
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h4, 32'h0, 32'h0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h4, 32'h0, 32'h4, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h8, 32'h4, 32'h8, 1, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'hC, 32'h8, 32'hC, 1, 0, 0, 0, 3));
        vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 1, 0, 32'h10, 32'h8, 32'h8, 1, 0, 0, 0, 4));
        vecs.push_back(mk(1, 32'hFFFF_FFF8, 0, 1, 0, 32'hC, 32'h0, 32'h0, 1, 0, 0, 0, 5));
        vecs.push_back(mk(2, 0, 32'h205, 1, 0, 32'h4, 32'h0, 32'h204, 1, 0, 0, 0, 6));
        vecs.push_back(mk(2, 0, 32'h10, 1, 0, 32'h208, 32'h204, 32'h10, 1, 0, 0, 0, 7));
        vecs.push_back(mk(1, 32'h6, 0, 1, 0, 32'h14, 32'h16, 32'h100, 0, 1, 1, 32'h10, 7));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h104, 32'h100, 32'h100, 1, 0, 0, 32'h10, 7));
        vecs.push_back(mk(2, 0, 32'h20, 1, 0, 32'h104, 32'h100, 32'h20, 1, 0, 0, 32'h10, 8));
        vecs.push_back(mk(3, 0, 0, 1, 0, 32'h24, 32'h20, 32'h100, 0, 1, 0, 32'h20, 8));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h104, 32'h100, 32'h100, 1, 0, 0, 32'h20, 8));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h104, 32'h100, 32'h100, 1, 0, 0, 32'h20, 8));
        vecs.push_back(mk(2, 0, 32'h41, 1, 0, 32'h104, 32'h100, 32'h40, 1, 0, 0, 32'h20, 9));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 0, 1, 1, 32'h44, 32'h40, 32'h40, 1, 0, 0, 32'h20, 9));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h44, 32'h40, 32'h44, 1, 0, 0, 32'h20, 10));
        vecs.push_back(mk(2, 0, 32'h202, 1, 0, 32'h48, 32'h44, 32'h100, 0, 1, 1, 32'h44, 10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h104, 32'h100, 32'h100, 1, 0, 0, 32'h44, 10));
        vecs.push_back(mk(2, 0, 32'hFFFF_FFFC, 1, 0, 32'h104, 32'h100, 32'hFFFF_FFFC, 1, 0, 0, 32'h44, 11));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 0, 0, 32'h44, 12));
        vecs.push_back(mk(1, 32'h24, 0, 1, 0, 32'h4, 32'h24, 32'h24, 1, 0, 0, 32'h44, 13));

        drive(0, 0, 0, 1, 0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        #1 chk_outs("reset", 32'h0, 0, 0, 0, 32'h0, 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].src, vecs[i].imm, vecs[i].alu, vecs[i].valid, vecs[i].stall);
            #1;
            chk($sformatf("vec%0d.PCPlus4", i), bus.PCPlus4, vecs[i].p4_pre);
            chk($sformatf("vec%0d.PCTarget", i), bus.PCTarget, vecs[i].tgt_pre);
            @(posedge CLK);
            #1 chk_outs($sformatf("vec%0d", i), vecs[i].pc, vecs[i].fetch, vecs[i].trap,
                        vecs[i].mis, vecs[i].fault, vecs[i].rc);
        end

        // Async reset mid-cycle, with a commit pending
        drive(0, 0, 0, 1, 0);
        #2 nRST = 1'b0;
        #1 chk_outs("async_rst", 32'h0, 0, 0, 0, 32'h0, 32'h0);
        @(posedge CLK);
        #1 chk_outs("rst_held", 32'h0, 0, 0, 0, 32'h0, 32'h0);
        nRST = 1'b1;
        #1 chk_outs("boot", 32'h0, 0, 0, 0, 32'h0, 32'h0);
        @(posedge CLK);
        #1 chk_outs("boot_exit", 32'h0, 1, 0, 0, 32'h0, 32'h0);

        // Randomized run from a fresh reset
        nRST = 1'b0;
        #1 nRST = 1'b1;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [1:0]  src;
            logic [31:0] imm, alu;
            logic        v, s;
            src = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            imm = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            alu = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFD);
            v   = ($urandom_range(0, 4) != 0);
            s   = ($urandom_range(0, 4) == 0);
            drive(src, imm, alu, v, s);
            #1;
            chk("rnd.PCPlus4", bus.PCPlus4, m_pc + 32'd4);
            chk("rnd.PCTarget", bus.PCTarget, m_pc + imm);
            model_step(src, imm, alu, v, s);
            @(posedge CLK);
            #1 chk_outs("rnd", m_pc, !m_booting && !m_in_trap, m_trap, m_mis, m_fault, m_rc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
